seg7_output_capture: RTL and testbench
======================================

Name: seg7_output_capture

Overview:
- Decodes the processor's 7-segment output buses (Tens, Ones) plus LED back into a binary value.
- Applies a stability filter so transient patterns are ignored.
- Logs every new stable display state into a small FIFO, drained through a valid/ready port.
- Sits beside the Test top: hardware-side capture of display results for on-board checking and for self-checking benches.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a display state is committed; must be ≥1.
- FIFO_DEPTH, 8: entries in the log FIFO; must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- tens_seg  in  7  Tens segment pattern.
- ones_seg  in  7  Ones segment pattern.
- led  in  1  processor LED.
- out_ready  in  1  consumer accepts the head entry.
- out_valid  out  1  FIFO non-empty.
- out_value  out  7  decoded value 0..99 of the head entry.
- out_led  out  1  LED state of the head entry.
- out_err  out  1  head entry contained an undecodable pattern.
- overflow  out  1  sticky: a commit was dropped because the FIFO was full.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset is asynchronous, active-high and clears everything: out_valid=0, out_value=0, out_led=0, out_err=0, overflow=0, level=0, FIFO empty, stability counter=0, candidate invalid, last-committed invalid.
- Segment encoding is active-high, seg[6]=a … seg[0]=g.
  - Digits 0..9 are 7E, 30, 6D, 79, 33, 5B, 5F, 70, 7F, 7B (hex).
  - Blank (00) on tens decodes as 0 (leading-zero blanking).
  - Blank on ones, or any other pattern on either digit, is an error: err=1, value=0.
- Sample register: {tens_seg, ones_seg, led} is registered on every clk edge into S. This is the only synchronisation stage; inputs are synchronous to clk.
- Stability filter, evaluated each edge:
  - If candidate is invalid or S≠candidate: candidate←S, cnt←0.
  - Else if cnt<STABLE_CYCLES-1: cnt←cnt+1.
  - A commit fires on the edge where S==candidate and cnt==STABLE_CYCLES-1, and either last-committed is invalid or candidate≠last-committed. On commit, last-committed←candidate.
  - After cnt saturates, no further commits occur until the input changes.
- Latency: a new value first captured into S at edge E0 is pushed at edge E0+STABLE_CYCLES+1. out_valid is high immediately after the push edge when the FIFO was empty (show-ahead head, no bypass).
- Glitches shorter than STABLE_CYCLES+1 samples never commit. Returning to the already-committed state never re-commits.
- Entry format: {err, led, value[6:0]} = 9 bits. value = tens*10+ones, computed combinationally from the decoded candidate at commit time.
- FIFO:
  - Pop occurs when out_valid && out_ready on an edge.
  - Push with FIFO full and no simultaneous pop: entry dropped, overflow←1 (sticky until Reset), last-committed still updated.
  - Push with FIFO full and simultaneous pop: both performed, level unchanged, no overflow.
  - Push with FIFO empty and out_ready=1 in the same cycle: the push is not visible to the pop, so level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH. level counts 0..FIFO_DEPTH.
- Reset mid-operation (during counting, or with FIFO partly full) discards all state. The first stable value after release is always committed, even if it equals the pre-reset state.

Decomposition:
- Package seg7_pkg holds:
  - the ten digit pattern constants and SEG_BLANK;
  - a seg_decode function returning {err, digit[3:0]};
  - the entry width constant (9).
- Sub-module sync_fifo (parameters WIDTH, DEPTH) implements storage, pointers, level and the full/empty logic.
- The filter and decode logic stay in seg7_output_capture.

Test Plan:
1. Reset, then hold tens=30, ones=6D, led=0 → out_valid rises 5 edges after first sample (STABLE_CYCLES=4), out_value=12, out_err=0, out_led=0. Pulse out_ready one cycle → level=0, out_valid=0.
2. From committed 12, drive ones=79 for 3 cycles, then back to 6D → no entry pushed, level stays 0.
3. tens=00, ones=7F, led=1 stable → entry value=8, led=1, err=0. Then ones=00 stable → entry value=0, err=1.
4. out_ready=0; present 10 distinct stable values 1..10 → level=8, overflow=1, drained entries are 1..8 in order.
5. With FIFO level=3 and cnt=2, assert Reset asynchronously (no edge) → level=0, out_valid=0 immediately. Release holding the same pattern → exactly one entry after 5 edges.
6. FIFO full (level=8), out_ready=1 at the same edge a commit fires → level stays 8, overflow=0, new entry appears at the tail.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for 7-segment display capture.
// Segment bit order is seg[6]=a ... seg[0]=g, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DIG_0 = 7'h7E;
    localparam logic [6:0] SEG_DIG_1 = 7'h30;
    localparam logic [6:0] SEG_DIG_2 = 7'h6D;
    localparam logic [6:0] SEG_DIG_3 = 7'h79;
    localparam logic [6:0] SEG_DIG_4 = 7'h33;
    localparam logic [6:0] SEG_DIG_5 = 7'h5B;
    localparam logic [6:0] SEG_DIG_6 = 7'h5F;
    localparam logic [6:0] SEG_DIG_7 = 7'h70;
    localparam logic [6:0] SEG_DIG_8 = 7'h7F;
    localparam logic [6:0] SEG_DIG_9 = 7'h7B;

    // Log entry layout: {err, led, value[6:0]}
    localparam int ENTRY_W = 9;

    // Returns {err, digit}. Blank decodes to 0 only where blanking is legal.
    function automatic logic [4:0] seg_decode(
        input logic [6:0] seg,
        input logic       blank_ok
    );
        logic [4:0] r;
        r = 5'h10;
        case (seg)
            SEG_DIG_0: r = 5'h00;
            SEG_DIG_1: r = 5'h01;
            SEG_DIG_2: r = 5'h02;
            SEG_DIG_3: r = 5'h03;
            SEG_DIG_4: r = 5'h04;
            SEG_DIG_5: r = 5'h05;
            SEG_DIG_6: r = 5'h06;
            SEG_DIG_7: r = 5'h07;
            SEG_DIG_8: r = 5'h08;
            SEG_DIG_9: r = 5'h09;
            SEG_BLANK: r = blank_ok ? 5'h00 : 5'h10;
            default:   r = 5'h10;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// A push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      lvl_q, lvl_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == (AW+1)'(DEPTH));
    assign level_o = lvl_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            lvl_d = lvl_q + 1'b1;
        end else if (do_pop && !do_push) begin
            lvl_d = lvl_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/seg7_output_capture.sv
// Samples the Tens/Ones/LED display, filters out transients and
// logs each newly stable display state into a drainable FIFO.
module seg7_output_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic [6:0]                  tens_seg,
    input  logic [6:0]                  ones_seg,
    input  logic                        led,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [6:0]                  out_value,
    output logic                        out_led,
    output logic                        out_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [14:0]        smp_q, smp_d;
    logic               smp_vld_q, smp_vld_d;
    logic [14:0]        cand_q, cand_d;
    logic               cand_vld_q, cand_vld_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [14:0]        last_q, last_d;
    logic               last_vld_q, last_vld_d;
    logic               ovf_q, ovf_d;

    logic               commit;
    logic [4:0]         tens_dec;
    logic [4:0]         ones_dec;
    logic               dec_err;
    logic [6:0]         dec_val;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;

    assign smp_d     = {tens_seg, ones_seg, led};
    assign smp_vld_d = 1'b1;

    assign commit = smp_vld_q && cand_vld_q
                 && (smp_q == cand_q)
                 && (cnt_q == CNT_MAX)
                 && (!last_vld_q || (cand_q != last_q));

    assign tens_dec = seg_decode(cand_q[14:8], 1'b1);
    assign ones_dec = seg_decode(cand_q[7:1], 1'b0);
    assign dec_err  = tens_dec[4] | ones_dec[4];
    assign dec_val  = dec_err ? 7'd0
                    : ({3'b0, tens_dec[3:0]} * 7'd10)
                      + {3'b0, ones_dec[3:0]};
    assign entry    = {dec_err, cand_q[0], dec_val};

    assign pop   = out_valid && out_ready;
    assign ovf_d = ovf_q | (commit && fifo_full && !pop);

    // Stability filter and last-committed tracking
    always_comb begin
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (smp_vld_q) begin
            if (!cand_vld_q || (smp_q != cand_q)) begin
                cand_d     = smp_q;
                cand_vld_d = 1'b1;
                cnt_d      = '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (commit) begin
            last_d     = cand_q;
            last_vld_d = 1'b1;
        end
    end

    // Sample, filter and sticky overflow registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            smp_q      <= '0;
            smp_vld_q  <= 1'b0;
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
            cnt_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            smp_q      <= smp_d;
            smp_vld_q  <= smp_vld_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (Reset),
        .push_i  (commit),
        .data_i  (entry),
        .pop_i   (out_ready),
        .data_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (level)
    );

    assign out_valid = !fifo_empty;
    assign out_err   = head[8];
    assign out_led   = head[7];
    assign out_value = head[6:0];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seg7_output_capture.sv
// Directed self-checking bench for seg7_output_capture.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_seg7_output_capture;

    logic       clk;
    logic       Reset;
    logic [6:0] tens_seg;
    logic [6:0] ones_seg;
    logic       led;
    logic       out_ready;
    logic       out_valid;
    logic [6:0] out_value;
    logic       out_led;
    logic       out_err;
    logic       overflow;
    logic [3:0] level;

    int n_chk;
    int n_fail;

    logic [6:0] dig [10];

    seg7_output_capture #(
        .STABLE_CYCLES (4),
        .FIFO_DEPTH    (8)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .tens_seg  (tens_seg),
        .ones_seg  (ones_seg),
        .led       (led),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_value (out_value),
        .out_led   (out_led),
        .out_err   (out_err),
        .overflow  (overflow),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_val(input int v, input logic l);
        tens_seg = dig[v / 10];
        ones_seg = dig[v % 10];
        led      = l;
    endtask

    // Edges after the first capture edge until out_valid; -1 on timeout.
    task automatic wait_valid(output int edges);
        edges = -1;
        step(1);
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (out_valid && edges < 0) edges = i;
        end
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        out_ready = 1'b0;
        set_val(0, 1'b0);
        step(3);
        n_chk++;
        if ({out_valid, out_value, out_led, out_err, overflow, level} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b val=%0d led=%b err=%b ovf=%b lvl=%0d want all 0",
                     out_valid, out_value, out_led, out_err, overflow, level);
        end
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        int e;
        tens_seg = 7'h30;
        ones_seg = 7'h6D;
        led = 1'b0;
        // Edges counted here include the commit at E0+5, then extra idle edges.
        e = -1;
        step(1);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            if (out_valid && e < 0) e = i;
        end
        n_chk++;
        if (e !== 5) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges want 5", e);
        end
        n_chk++;
        if (out_value !== 7'd12 || out_err !== 1'b0 || out_led !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_entry: got val=%0d err=%b led=%b want 12 0 0",
                     out_value, out_err, out_led);
        end
        step(6);
        n_chk++;
        if (level !== 4'd1) begin
            n_fail++;
            $display("FAIL basic_no_recommit: got level %0d want 1", level);
        end
        pop_one();
        n_chk++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop: got level=%0d valid=%b want 0 0", level, out_valid);
        end
    endtask

    task automatic test_glitch();
        ones_seg = 7'h79;
        step(3);
        ones_seg = 7'h6D;
        step(12);
        n_chk++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_ignored: got level=%0d valid=%b want 0 0", level, out_valid);
        end
    endtask

    task automatic test_blank();
        int e;
        tens_seg = 7'h00;
        ones_seg = 7'h7F;
        led = 1'b1;
        wait_valid(e);
        n_chk++;
        if (e !== 5 || out_value !== 7'd8 || out_led !== 1'b1 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_tens: got e=%0d val=%0d led=%b err=%b want 5 8 1 0",
                     e, out_value, out_led, out_err);
        end
        pop_one();
        ones_seg = 7'h00;
        wait_valid(e);
        n_chk++;
        if (out_valid !== 1'b1 || out_value !== 7'd0 || out_err !== 1'b1 || out_led !== 1'b1) begin
            n_fail++;
            $display("FAIL blank_ones_err: got v=%b val=%0d err=%b led=%b want 1 0 1 1",
                     out_valid, out_value, out_err, out_led);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int v = 1; v <= 10; v++) begin
            set_val(v, 1'b0);
            step(8);
        end
        n_chk++;
        if (level !== 4'd8 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_state: got level=%0d ovf=%b want 8 1", level, overflow);
        end
        for (int v = 1; v <= 8; v++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_value !== v[6:0]) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: got v=%b val=%0d want 1 %0d",
                         v, out_valid, out_value, v);
            end
            pop_one();
        end
        n_chk++;
        if (level !== 4'd0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got level=%0d ovf=%b want 0 1", level, overflow);
        end
    endtask

    task automatic test_mid_reset();
        int e;
        for (int v = 21; v <= 23; v++) begin
            set_val(v, 1'b0);
            step(8);
        end
        n_chk++;
        if (level !== 4'd3) begin
            n_fail++;
            $display("FAIL rst_pre_level: got %0d want 3", level);
        end
        set_val(45, 1'b1);
        step(4);
        #2;
        Reset = 1'b1;
        #1;
        n_chk++;
        if (level !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got level=%0d valid=%b ovf=%b want 0 0 0",
                     level, out_valid, overflow);
        end
        @(posedge clk);
        #1;
        Reset = 1'b0;
        wait_valid(e);
        n_chk++;
        if (e !== 5 || level !== 4'd1 || out_value !== 7'd45 || out_led !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_recommit: got e=%0d level=%0d val=%0d led=%b want 5 1 45 1",
                     e, level, out_value, out_led);
        end
    endtask

    task automatic test_back_to_back();
        for (int v = 50; v <= 56; v++) begin
            set_val(v, 1'b0);
            step(8);
        end
        n_chk++;
        if (level !== 4'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got level=%0d ovf=%b want 8 0", level, overflow);
        end
        set_val(60, 1'b0);
        step(5);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        n_chk++;
        if (level !== 4'd8 || overflow !== 1'b0 || out_value !== 7'd50) begin
            n_fail++;
            $display("FAIL b2b_push_pop: got level=%0d ovf=%b head=%0d want 8 0 50",
                     level, overflow, out_value);
        end
        for (int k = 0; k < 8; k++) begin
            int exp;
            exp = (k < 7) ? 50 + k : 60;
            n_chk++;
            if (out_valid !== 1'b1 || out_value !== exp[6:0]) begin
                n_fail++;
                $display("FAIL b2b_drain_%0d: got v=%b val=%0d want 1 %0d",
                         k, out_valid, out_value, exp);
            end
            pop_one();
        end
        n_chk++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: got level=%0d valid=%b want 0 0", level, out_valid);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        dig[0] = 7'h7E; dig[1] = 7'h30; dig[2] = 7'h6D; dig[3] = 7'h79;
        dig[4] = 7'h33; dig[5] = 7'h5B; dig[6] = 7'h5F; dig[7] = 7'h70;
        dig[8] = 7'h7F; dig[9] = 7'h7B;
        tens_seg = 7'h00;
        ones_seg = 7'h00;
        led = 1'b0;
        out_ready = 1'b0;
        Reset = 1'b1;
        #2;
        test_reset();
        test_basic();
        test_glitch();
        test_blank();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
